inst_fetch_queue: RTL

Instruction fetch stage placed directly upstream of the instruction memory. Holds the program counter, drives the word-indexed fetch address, captures the combinationally returned instruction into a small in-order queue, and hands {pc, inst} pairs to decode through a valid/ready handshake. Branch and jump redirects from execute flush the queue and restart fetch at the new target.

---
 rtl/inst_fetch_queue.sv | 84 ++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and
// buffers {pc, inst} pairs in a small in-order queue feeding decode; redirects flush it.
module inst_fetch_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_WIDTH-1:0]     inst_addr,
  input  logic [INST_WIDTH-1:0]     inst,
  input  logic                      redirect_valid,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc,
  output logic                      id_valid,
  input  logic                      id_ready,
  output logic [INST_WIDTH-1:0]     id_inst,
  output logic [ADDR_WIDTH-1:0]     id_pc,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0]                  pc_q, pc_d;
  logic [PW-1:0]                          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                          count_q, count_d;
  logic [DEPTH-1:0][ADDR_WIDTH-1:0]       ent_pc_q, ent_pc_d;
  logic [DEPTH-1:0][INST_WIDTH-1:0]       ent_inst_q, ent_inst_d;
  logic                                   pop, push;

  assign inst_addr = pc_q;
  assign count     = count_q;
  assign id_valid  = (count_q != '0);
  assign id_pc     = ent_pc_q[rd_ptr_q];
  assign id_inst   = ent_inst_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full queue still streams.
  assign pop  = id_valid & id_ready;
  assign push = !redirect_valid && ((count_q < CW'(DEPTH)) || pop);

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ent_pc_d   = ent_pc_q;
    ent_inst_d = ent_inst_q;
    if (redirect_valid) begin
      // Flush wins over everything; the word on inst this cycle is dropped.
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        ent_pc_d[wr_ptr_q]   = pc_q;
        ent_inst_d[wr_ptr_q] = inst;
        pc_d                 = pc_q + ADDR_WIDTH'(1);
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ent_pc_q   <= '0;
      ent_inst_q <= '0;
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ent_pc_q   <= ent_pc_d;
      ent_inst_q <= ent_inst_d;
    end
  end
endmodule
